// File: rtl/axi4l_gpio_pkg.sv
// Shared constants, FSM state types and helpers for the AXI4-Lite GPIO slave.
package axi4l_gpio_pkg;

  // Register byte offsets within the slave window
  localparam int unsigned GPIO_IN_OFS  = 32'h0;
  localparam int unsigned GPIO_OUT_OFS = 32'h4;
  localparam int unsigned IRQ_EN_OFS   = 32'h8;
  localparam int unsigned IRQ_STAT_OFS = 32'hC;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} wr_state_e;
  typedef enum logic {R_IDLE, R_DATA} rd_state_e;

  // Expand byte strobes into a 32-bit bit mask
  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    logic [31:0] mask;
    for (int i = 0; i < 4; i++) begin
      mask[8*i +: 8] = {8{strb[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/gpio_in_sync.sv
// Two-flop synchronizer for asynchronous GPIO pins, plus a rising-edge detector
// that only exists when AXI4L_GPIO_IRQ_EN is defined.
module gpio_in_sync
  import axi4l_gpio_pkg::*;
#(
  parameter int unsigned GPIO_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] sync_out
`ifdef AXI4L_GPIO_IRQ_EN
  ,
  output logic [GPIO_W-1:0] rise
`endif
);

  logic [GPIO_W-1:0] s1_q, s2_q;

  // Metastability chain; s2 is the first stage safe to use in logic
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= gpio_in;
      s2_q <= s1_q;
    end
  end

  assign sync_out = s2_q;

`ifdef AXI4L_GPIO_IRQ_EN
  logic [GPIO_W-1:0] s3_q;

  // One extra stage delays s2 so a 0->1 transition shows for exactly one cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s3_q <= '0;
    end else begin
      s3_q <= s2_q;
    end
  end

  assign rise = s2_q & ~s3_q;
`endif

endmodule

// File: rtl/axi4l_gpio_slv.sv
// AXI4-Lite GPIO register slave: synchronized input capture, output register,
// and an optional edge interrupt enabled by defining AXI4L_GPIO_IRQ_EN.
module axi4l_gpio_slv
  import axi4l_gpio_pkg::*;
#(
  parameter int unsigned       ADDR_W  = 6,
  parameter int unsigned       GPIO_W  = 32,
  parameter logic [GPIO_W-1:0] OUT_RST = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              irq
);

  // Word indices; the two address LSBs never take part in decode
  localparam logic [ADDR_W-3:0] IdxIn   = (ADDR_W-2)'(GPIO_IN_OFS >> 2);
  localparam logic [ADDR_W-3:0] IdxOut  = (ADDR_W-2)'(GPIO_OUT_OFS >> 2);
  localparam logic [ADDR_W-3:0] IdxEn   = (ADDR_W-2)'(IRQ_EN_OFS >> 2);
  localparam logic [ADDR_W-3:0] IdxStat = (ADDR_W-2)'(IRQ_STAT_OFS >> 2);

  wr_state_e         w_state_q;
  logic              aw_done_q, w_done_q;
  logic [ADDR_W-3:0] aw_idx_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;
  logic              awready_q, wready_q, bvalid_q;
  logic [1:0]        bresp_q;

  rd_state_e         r_state_q;
  logic              arready_q, rvalid_q;
  logic [31:0]       rdata_q, rd_val;
  logic [1:0]        rresp_q, rd_resp;
  logic [ADDR_W-3:0] rd_idx;

  logic [GPIO_W-1:0] gpio_out_q, gpio_sync;
  logic              wr_commit, wr_mapped;
  logic [31:0]       wr_mask;

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  assign wr_commit = (w_state_q == W_IDLE) && aw_done_q && w_done_q;
  assign wr_mask   = strb_mask(wstrb_q);
  assign wr_mapped = (aw_idx_q == IdxIn) || (aw_idx_q == IdxOut) ||
                     (aw_idx_q == IdxEn) || (aw_idx_q == IdxStat);

`ifdef AXI4L_GPIO_IRQ_EN
  logic [GPIO_W-1:0] gpio_rise, irq_en_q, irq_stat_q, stat_clr;
  logic              irq_q;

  gpio_in_sync #(
    .GPIO_W (GPIO_W)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .gpio_in  (gpio_in),
    .sync_out (gpio_sync),
    .rise     (gpio_rise)
  );
`else
  gpio_in_sync #(
    .GPIO_W (GPIO_W)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .gpio_in  (gpio_in),
    .sync_out (gpio_sync)
  );
`endif

  // Write channel: latch AW and W independently, commit once both are held
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state_q <= W_IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      aw_idx_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      unique case (w_state_q)
        W_IDLE: begin
          if (wr_commit) begin
            bvalid_q  <= 1'b1;
            bresp_q   <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            w_state_q <= W_RESP;
          end else begin
            awready_q <= !aw_done_q && !(s_axi_awvalid && awready_q);
            wready_q  <= !w_done_q && !(s_axi_wvalid && wready_q);
            if (s_axi_awvalid && awready_q) begin
              aw_done_q <= 1'b1;
              aw_idx_q  <= s_axi_awaddr[ADDR_W-1:2];
            end
            if (s_axi_wvalid && wready_q) begin
              w_done_q <= 1'b1;
              wdata_q  <= s_axi_wdata;
              wstrb_q  <= s_axi_wstrb;
            end
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            w_state_q <= W_IDLE;
          end
        end
      endcase
    end
  end

  // Output register, updated on the commit edge with byte-lane masking
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gpio_out_q <= OUT_RST;
    end else if (wr_commit && aw_idx_q == IdxOut) begin
      gpio_out_q <= GPIO_W'((32'(gpio_out_q) & ~wr_mask) | (s_axi_wdata & 32'h0) |
                            (wdata_q & wr_mask));
    end
  end

`ifdef AXI4L_GPIO_IRQ_EN
  assign stat_clr = (wr_commit && aw_idx_q == IdxStat) ? GPIO_W'(wdata_q & wr_mask) : '0;

  // Interrupt enable/status; a new edge beats a same-cycle W1C clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_en_q   <= '0;
      irq_stat_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      if (wr_commit && aw_idx_q == IdxEn) begin
        irq_en_q <= GPIO_W'((32'(irq_en_q) & ~wr_mask) | (wdata_q & wr_mask));
      end
      irq_stat_q <= (irq_stat_q & ~stat_clr) | gpio_rise;
      irq_q      <= |(irq_stat_q & irq_en_q);
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  // Read decode against current register state (pre-write on a collision)
  always_comb begin
    rd_idx  = s_axi_araddr[ADDR_W-1:2];
    rd_val  = '0;
    rd_resp = RESP_OKAY;
    case (rd_idx)
      IdxIn:  rd_val = 32'(gpio_sync);
      IdxOut: rd_val = 32'(gpio_out_q);
`ifdef AXI4L_GPIO_IRQ_EN
      IdxEn:   rd_val = 32'(irq_en_q);
      IdxStat: rd_val = 32'(irq_stat_q);
`else
      IdxEn, IdxStat: rd_val = '0;
`endif
      default: rd_resp = RESP_SLVERR;
    endcase
  end

  // Read channel: one-cycle latency, data held until accepted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      unique case (r_state_q)
        R_IDLE: begin
          if (s_axi_arvalid && arready_q) begin
            rdata_q   <= rd_val;
            rresp_q   <= rd_resp;
            rvalid_q  <= 1'b1;
            arready_q <= 1'b0;
            r_state_q <= R_DATA;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_DATA: begin
          if (s_axi_rready) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            r_state_q <= R_IDLE;
          end
        end
      endcase
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign gpio_out      = gpio_out_q;

endmodule
